// File: rtl/sync_framer_tx.sv
// Serial frame transmitter: sync header, MSB-first payload and an even-parity bit.
// Back-to-back frames are accepted in the parity cycle, so the stream has no gaps.
//
// state  | meaning
// IDLE   | no frame, outputs quiet, ready for start
// SYNC   | sync header bits on dout
// DATA   | payload bits on dout
// PARITY | parity bit on dout, done high, ready for the next start
module sync_framer_tx #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done
);

    localparam int         MAX_W    = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int         CNT_W    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [7:0] SYNC_EXT = 8'(SYNC_PAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] sh_n;
    logic              par;
    logic              par_n;
    logic              dout_n;
    logic              valid_n;
    logic              busy_n;
    logic              done_n;
    logic              accept;
    logic              last_bit;
    logic [2:0]        sync_idx;

    assign ready    = (state == IDLE) || (state == PARITY);
    assign accept   = start && ready;
    assign last_bit = (cnt == '0);
    // cnt counts bits still to follow in the current state; the next sync bit sits one below it
    assign sync_idx = 3'(cnt - CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = SYNC;
            SYNC:    if (last_bit) state_n = DATA;
            DATA:    if (last_bit) state_n = PARITY;
            PARITY:  state_n = accept ? SYNC : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cnt_n   = cnt;
        sh_n    = sh;
        par_n   = par;
        dout_n  = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        if (accept) begin
            sh_n    = data_in;
            par_n   = ^data_in;
            cnt_n   = CNT_W'(SYNC_W - 1);
            dout_n  = SYNC_PAT[SYNC_W-1];
            valid_n = 1'b1;
            busy_n  = 1'b1;
        end else begin
            case (state)
                SYNC: begin
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    if (last_bit) begin
                        dout_n = sh[DATA_W-1];
                        sh_n   = sh << 1;
                        cnt_n  = CNT_W'(DATA_W - 1);
                    end else begin
                        dout_n = SYNC_EXT[sync_idx];
                        cnt_n  = cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    if (last_bit) begin
                        dout_n = par;
                        done_n = 1'b1;
                    end else begin
                        dout_n = sh[DATA_W-1];
                        sh_n   = sh << 1;
                        cnt_n  = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            sh         <= '0;
            par        <= 1'b0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            sh         <= sh_n;
            par        <= par_n;
            dout       <= dout_n;
            dout_valid <= valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_sync_framer_tx.sv
// Bench for sync_framer_tx: frame-level reference model compared every cycle,
// directed frames with literal expectations, random traffic and a 1-bit configuration.
module tb_sync_framer_tx;

    localparam int         DW   = 8;
    localparam int         SW   = 4;
    localparam logic [3:0] SP   = 4'b1011;
    localparam int         FLEN = SW + DW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ready, dout, dout_valid, busy, done;

    logic          start1 = 1'b0;
    logic [0:0]    data1 = 1'b0;
    logic          ready1, dout1, dout_valid1, busy1, done1;

    int n_cmp = 0;
    int n_bad = 0;

    sync_framer_tx #(.DATA_W(DW), .SYNC_W(SW), .SYNC_PAT(SP)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .ready(ready), .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
    );

    sync_framer_tx #(.DATA_W(1), .SYNC_W(1), .SYNC_PAT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(data1),
        .ready(ready1), .dout(dout1), .dout_valid(dout_valid1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the frame is a list of bits and pos says which one is on dout.
    bit frm[FLEN];
    int pos = -1;

    function automatic void build_frame(input logic [DW-1:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < SW; i++) frm[i] = SP[SW-1-i];
        for (int j = 0; j < DW; j++) begin
            frm[SW+j] = d[DW-1-j];
            if (d[DW-1-j]) ones++;
        end
        frm[FLEN-1] = (ones % 2) == 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos = -1;
        end else begin
            if (start && ((pos < 0) || (pos == FLEN - 1))) begin
                build_frame(data_in);
                pos = 0;
            end else if (pos >= 0) begin
                pos++;
                if (pos == FLEN) pos = -1;
            end
        end
    end

    // Observed valid bits, their done flags, and number of separate valid runs.
    bit obs[$];
    bit obs_done[$];
    int runs = 0;
    bit prev_valid = 1'b0;

    always @(negedge clk) begin
        chk("dout",       dout,       (pos >= 0) ? frm[pos] : 1'b0);
        chk("dout_valid", dout_valid, pos >= 0);
        chk("busy",       busy,       pos >= 0);
        chk("done",       done,       pos == FLEN - 1);
        chk("ready",      ready,      (pos < 0) || (pos == FLEN - 1));
        if (rst && dout_valid) begin
            obs.push_back(dout);
            obs_done.push_back(done);
            if (!prev_valid) runs++;
        end
        prev_valid = rst && dout_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs.delete();
        obs_done.delete();
        runs = 0;
    endtask

    function automatic logic [63:0] obs_vec();
        logic [63:0] v;
        v = '0;
        foreach (obs[i]) v = (v << 1) | 64'(obs[i]);
        return v;
    endfunction

    function automatic int done_count();
        int c;
        c = 0;
        foreach (obs_done[i]) if (obs_done[i]) c++;
        return c;
    endfunction

    initial begin
        int guard;

        // Reset state
        tick(1);
        chk("rst_dout", dout, 1'b0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_ready", ready, 1'b1);

        // Single frame A5, start present at the first edge after reset release
        start   = 1'b1;
        data_in = 8'hA5;
        clear_obs();
        rst = 1'b1;
        tick(1);
        start   = 1'b0;
        data_in = 8'hFF;
        tick(15);
        chk("a5_len", obs.size(), 13);
        chk("a5_bits", obs_vec(), 64'b1011_10100101_0);
        chk("a5_done_cnt", done_count(), 1);
        chk("a5_done_last", (obs_done.size() == 13) ? obs_done[12] : 1'b0, 1'b1);
        chk("a5_idle", dout_valid, 1'b0);

        // Odd-parity payload
        clear_obs();
        start   = 1'b1;
        data_in = 8'h01;
        tick(1);
        start = 1'b0;
        tick(15);
        chk("p01_len", obs.size(), 13);
        chk("p01_tail", obs_vec() & 64'h1FF, 64'b00000001_1);
        chk("p01_done_last", (obs_done.size() == 13) ? obs_done[12] : 1'b0, 1'b1);

        // Back-to-back: start held high, second payload captured in the parity cycle
        clear_obs();
        start   = 1'b1;
        data_in = 8'hA5;
        tick(1);
        data_in = 8'h3C;
        tick(13);
        start = 1'b0;
        tick(16);
        chk("b2b_len", obs.size(), 26);
        chk("b2b_bits", obs_vec(), {38'b0, 13'b1011_10100101_0, 13'b1011_00111100_0});
        chk("b2b_runs", runs, 1);
        chk("b2b_done_cnt", done_count(), 2);

        // Start pulses while busy are ignored
        clear_obs();
        start   = 1'b1;
        data_in = 8'h5A;
        tick(1);
        start = 1'b0;
        for (int c = 2; c <= 11; c++) begin
            start   = c[0];
            data_in = 8'(c * 37);
            tick(1);
            if (c == 6) chk("busy_ready_low", ready, 1'b0);
        end
        start = 1'b0;
        tick(8);
        chk("ign_len", obs.size(), 13);
        chk("ign_bits", obs_vec(), 64'b1011_01011010_0);
        chk("ign_runs", runs, 1);

        // Reset in the middle of DATA bit 3
        start   = 1'b1;
        data_in = 8'hC3;
        tick(1);
        start = 1'b0;
        guard = 0;
        while (pos != SW + 3 && guard < 40) begin
            tick(1);
            guard++;
        end
        chk("reach_data3", pos, SW + 3);
        chk("pre_rst_valid", dout_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_dout", dout, 1'b0);
        chk("arst_valid", dout_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_ready", ready, 1'b1);
        tick(2);
        rst = 1'b1;
        tick(5);
        chk("post_rst_valid", dout_valid, 1'b0);

        // Random traffic, occasionally holding start for back-to-back frames
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) start = ~start;
            else start = ($urandom_range(0, 5) == 0);
            data_in = 8'($urandom);
            tick(1);
        end
        start = 1'b0;
        tick(FLEN + 2);

        // One-bit configuration: frame 1,1,1 with done on the third bit
        start1 = 1'b1;
        data1  = 1'b1;
        tick(1);
        start1 = 1'b0;
        data1  = 1'b0;
        chk("w1_b0", {dout_valid1, dout1, done1}, 3'b110);
        tick(1);
        chk("w1_b1", {dout_valid1, dout1, done1}, 3'b110);
        tick(1);
        chk("w1_b2", {dout_valid1, dout1, done1}, 3'b111);
        tick(1);
        chk("w1_idle", {dout_valid1, busy1, ready1}, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_framer_tx.md
SYNC_FRAMER_TX -- requirements
Module: sync_framer_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload width in bits; legal range 1..32.
REQ-002 The block SHALL have parameter SYNC_W, default 4, meaning sync header width in bits; legal range 1..8.
REQ-003 The block SHALL have parameter SYNC_PAT, default 4'b1011, SYNC_W bits wide, meaning the sync header pattern.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: frame request, sampled on the rising edge of clk.
REQ-007 The block SHALL have port data_in, input, DATA_W bits: payload, captured when a frame is accepted.
REQ-008 The block SHALL have port ready, output, 1 bit: high when a start on the next edge will be accepted.
REQ-009 The block SHALL have port dout, output, 1 bit: serial bit stream.
REQ-010 The block SHALL have port dout_valid, output, 1 bit: high while dout carries a frame bit.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: high for exactly the cycle in which the parity bit is on dout.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SYNC, DATA and PARITY.
REQ-014 Frame format SHALL be: SYNC_PAT MSB first, then data_in MSB first, then one even-parity bit (XOR of all captured data bits); length SYNC_W+DATA_W+1 bits (13 at defaults).
REQ-015 dout, dout_valid, busy and done SHALL be registered outputs; ready SHALL be combinational and equal to (state==IDLE) or (state==PARITY).
REQ-016 A start sampled high at edge n with ready=1 SHALL be accepted: data_in is captured, and after edge n the FSM is in SYNC with dout=SYNC_PAT[SYNC_W-1], dout_valid=1 and busy=1.
REQ-017 The frame bit at index i (0-based) SHALL be on dout during the cycle following edge n+i; one bit per clock, with no gaps inside a frame.
REQ-018 Transitions SHALL be: SYNC->DATA after SYNC_W bits; DATA->PARITY after DATA_W bits; PARITY->SYNC if start is sampled high at the edge ending PARITY; otherwise PARITY->IDLE.
REQ-019 Back-to-back frames SHALL have zero idle cycles: the first sync bit of the new frame directly follows the parity bit, using the newly captured data_in.
REQ-020 start SHALL be ignored while ready=0, and data_in changes SHALL have no effect on a frame in progress.
REQ-021 In IDLE: dout=0, dout_valid=0, busy=0, done=0.
REQ-022 On the edge PARITY->IDLE: dout_valid, busy and done SHALL go to 0 and dout SHALL go to 0.
REQ-023 Bit counters SHALL be sized for max(SYNC_W,DATA_W) and reload at each state entry; no wrap beyond the state's bit count.
REQ-024 The block SHALL hold no other state beyond the FSM, bit counter, payload shift register and parity register.

Reset
REQ-025 rst=0 SHALL immediately (asynchronously) force state IDLE, dout=0, dout_valid=0, busy=0, done=0, and clear the counter, shift register and parity register.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further frame bits emitted; after rst returns to 1, the block is in IDLE with ready=1.
REQ-027 A start coinciding with the first edge after reset release SHALL be accepted normally.

Verification
REQ-028 Single frame: data_in=8'hA5, start pulsed one cycle -> dout sequence 1,0,1,1, 1,0,1,0,0,1,0,1, 0 on consecutive cycles; dout_valid high 13 cycles; done high only on the 13th; then IDLE.
REQ-029 Odd parity data: data_in=8'h01 -> last 9 bits 0,0,0,0,0,0,0,1, 1; done=1 with parity bit 1.
REQ-030 Back-to-back: start held high with data_in=8'hA5 then 8'h3C captured at PARITY -> 26 contiguous valid bits, second frame parity 0, busy never drops between frames.
REQ-031 Start while busy: extra start pulses during cycles 2..11 of a frame -> ignored; only one frame emitted; ready=0 throughout those cycles.
REQ-032 Reset mid-frame: rst=0 asserted during DATA bit 3 -> outputs 0 immediately without waiting for clk; after release with start low, dout_valid stays 0.
REQ-033 Parameter sweep: DATA_W=1, SYNC_W=1, SYNC_PAT=1'b1, data_in=1 -> frame 1,1,1 in 3 cycles, with done on the third cycle.
